c17_stress_scheduler: RTL and testbench
=======================================

// Module: c17_stress_scheduler
// PURPOSE
//  Sequences stress vectors into NUM_PART replicated c17 NAND2 partitions for the aging experiment.
//  Each epoch, partition p is toggled (active) for duty[p] cycles, then parked on a static vector.
//  Partition responses are checked against an internal golden c17 model; mismatches are counted.
//  Sits between the experiment host/testbench and the partition netlists; owns all partition inputs.
// PARAMETERS
//  NUM_PART   4             number of c17 partitions (1..6)
//  EPOCH_LEN  256           cycles per epoch (2..65535)
//  CHECK_LAT  1             cycles from part_vec change to valid part_resp (0..4)
//  LFSR_SEED  32'hACE1_0001 nonzero LFSR reset seed
// PORTS
//  clk         in   1            rising-edge clock
//  rst_n       in   1            synchronous active-low reset
//  start       in   1            pulse: begin run (ignored unless IDLE)
//  stop        in   1            pulse: abort run (ignored in IDLE/DONE)
//  num_epochs  in   16           epochs to run; sampled at start
//  duty_cfg    in   NUM_PART*8   duty[p] = bits [8p+7:8p], active cycles per epoch; sampled at start
//  park_vec    in   5            idle vector {N7,N6,N3,N2,N1}; sampled at start
//  part_vec    out  NUM_PART*5   partition p inputs {N7,N6,N3,N2,N1} at [5p+4:5p]
//  part_resp   in   NUM_PART*2   partition p outputs {N23,N22} at [2p+1:2p]
//  cnt_sel     in   3            partition index for act_cnt readback
//  act_cnt     out  32           active-cycle count of partition cnt_sel (registered)
//  busy        out  1            high in LOAD/RUN/DRAIN
//  done        out  1            one-cycle pulse on entering DONE
//  epoch_idx   out  16           current epoch number, 0-based
//  err_count   out  16           total mismatches, saturating at 16'hFFFF
//  err_flag    out  1            sticky: err_count != 0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): FSM=IDLE; part_vec=0; busy=done=err_flag=0; epoch_idx=err_count=0;
//   act_cnt and all per-partition counters = 0; LFSR = LFSR_SEED; check pipeline cleared.
//   Reset mid-run aborts immediately; no done pulse.
//  FSM: IDLE -start-> LOAD (latch cfg, clear err_count/err_flag/act counters/epoch_idx, cyc=0).
//   LOAD -> DONE if num_epochs==0, else RUN.
//   RUN: per cycle, active[p] = (cyc < duty[p]); duty[p] >= EPOCH_LEN means always active, 0 never.
//    active p: part_vec[p] = lfsr[5p+4:5p]; idle p: part_vec[p] = park_vec_latched; act counter p += 1 if active.
//    LFSR 32-bit Fibonacci, taps x^32+x^22+x^2+x+1, advances every RUN cycle.
//    cyc wraps EPOCH_LEN-1 -> 0 and epoch_idx += 1; after last cycle of epoch num_epochs-1 -> DRAIN.
//    stop in RUN -> DRAIN next cycle (current cycle's vector still checked).
//   DRAIN: part_vec held on park_vec for CHECK_LAT+1 cycles so in-flight checks retire -> DONE.
//   DONE: done=1 for one cycle, then IDLE. Counters and err_count hold until next start/reset.
//  Check: golden N10=~(N1&N3), N11=~(N3&N6), N16=~(N2&N11), N19=~(N11&N7),
//   N22=~(N10&N16), N23=~(N16&N19) on each applied part_vec (active and parked).
//   Expected values delayed CHECK_LAT cycles, compared to part_resp; check valid only for vectors applied in RUN.
//   err_count += popcount of mismatching partitions that cycle (multi-error add), saturating.
//  Simultaneous start+stop in IDLE: start wins, stop ignored. start while busy: ignored.
//  cnt_sel >= NUM_PART: act_cnt reads 0. act_cnt updates 1 cycle after cnt_sel/counter change.
//  Act counters saturate at 32'hFFFF_FFFF.
// TESTING
//  1 Reset: rst_n=0 2 cycles mid-RUN -> IDLE, part_vec=0, busy=0, err_count=0, no done pulse.
//  2 EPOCH_LEN=8, duty={0,3,8,255}, num_epochs=2, ideal c17 models -> act_cnt = 0,6,16,16; err_count=0; done 1 cycle after DRAIN.
//  3 Partition 1 N22 stuck-at-0, park_vec=5'b11111 (N22=1), duty all 0, 1 epoch of 8 -> err_count=8, err_flag=1.
//  4 num_epochs=0 start -> busy high 1 cycle (LOAD), done pulse, part_vec never leaves reset value.
//  5 stop asserted 3 cycles into RUN -> DRAIN CHECK_LAT+1 cycles, done pulse, epoch_idx=0, act_cnt(duty>=3)=3.
//  6 Force all partitions wrong for 70000 cycles -> err_count saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/c17_stress_scheduler.sv
// Drives NUM_PART replicated c17 partitions with duty-cycled LFSR stress vectors per epoch,
// parks idle partitions on a static vector, and counts response mismatches against a golden c17.
module c17_stress_scheduler #(
    parameter int          NUM_PART  = 4,
    parameter int          EPOCH_LEN = 256,
    parameter int          CHECK_LAT = 1,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [15:0]           num_epochs_i,
    input  logic [NUM_PART*8-1:0] duty_cfg_i,
    input  logic [4:0]            park_vec_i,
    output logic [NUM_PART*5-1:0] part_vec_o,
    input  logic [NUM_PART*2-1:0] part_resp_i,
    input  logic [2:0]            cnt_sel_i,
    output logic [31:0]           act_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           epoch_idx_o,
    output logic [15:0]           err_count_o,
    output logic                  err_flag_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [15:0] LAST_CYC = 16'(EPOCH_LEN - 1);
    localparam logic [2:0]  LAST_DRN = 3'(CHECK_LAT);

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[0] & v[2]);
        n11 = ~(v[2] & v[3]);
        n16 = ~(v[1] & n11);
        n19 = ~(n11 & v[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [NUM_PART*2-1:0] golden_all(input logic [NUM_PART*5-1:0] v);
        logic [NUM_PART*2-1:0] r;
        r = '0;
        for (int p = 0; p < NUM_PART; p++) begin
            r[2*p +: 2] = c17(v[5*p +: 5]);
        end
        return r;
    endfunction

    state_e                state_q, state_d;
    logic [15:0]           cyc_q, cyc_d;
    logic [15:0]           epoch_q, epoch_d;
    logic [2:0]            drain_q, drain_d;
    logic [15:0]           num_ep_q, num_ep_d;
    logic [NUM_PART*8-1:0] duty_q, duty_d;
    logic [4:0]            park_q, park_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [NUM_PART*5-1:0] part_vec_q, part_vec_d;
    logic [15:0]           err_q, err_d;
    logic [31:0]           act_q [NUM_PART];
    logic [31:0]           act_d [NUM_PART];
    logic [31:0]           act_cnt_q, act_sel;
    logic [NUM_PART*2-1:0] exp_q [CHECK_LAT+1];
    logic [CHECK_LAT:0]    vld_q;
    logic [NUM_PART-1:0]   active;
    logic [NUM_PART-1:0]   mism;
    logic [3:0]            n_err;
    logic [16:0]           err_sum;
    logic                  clear_run;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        epoch_d    = epoch_q;
        drain_d    = drain_q;
        num_ep_d   = num_ep_q;
        duty_d     = duty_q;
        park_d     = park_q;
        lfsr_d     = lfsr_q;
        part_vec_d = part_vec_q;
        act_d      = act_q;
        clear_run  = 1'b0;
        for (int p = 0; p < NUM_PART; p++) begin
            active[p] = (cyc_q < {8'd0, duty_q[8*p +: 8]});
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    num_ep_d  = num_epochs_i;
                    duty_d    = duty_cfg_i;
                    park_d    = park_vec_i;
                    cyc_d     = '0;
                    epoch_d   = '0;
                    clear_run = 1'b1;
                    for (int p = 0; p < NUM_PART; p++) begin
                        act_d[p] = '0;
                    end
                end
            end
            S_LOAD: begin
                state_d = (num_ep_q == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                drain_d = '0;
                lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
                for (int p = 0; p < NUM_PART; p++) begin
                    part_vec_d[5*p +: 5] = active[p] ? lfsr_q[5*p +: 5] : park_q;
                    if (active[p] && act_q[p] != 32'hFFFF_FFFF) begin
                        act_d[p] = act_q[p] + 32'd1;
                    end
                end
                // The last epoch ends in DRAIN without advancing epoch_idx past num_epochs-1.
                if (stop_i) begin
                    state_d = S_DRAIN;
                end else if (cyc_q == LAST_CYC) begin
                    if (epoch_q == num_ep_q - 16'd1) begin
                        state_d = S_DRAIN;
                    end else begin
                        cyc_d   = '0;
                        epoch_d = epoch_q + 16'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_DRAIN: begin
                part_vec_d = {NUM_PART{park_q}};
                if (drain_q == LAST_DRN) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        n_err = '0;
        for (int p = 0; p < NUM_PART; p++) begin
            mism[p] = vld_q[CHECK_LAT] && (part_resp_i[2*p +: 2] != exp_q[CHECK_LAT][2*p +: 2]);
            n_err   = n_err + 4'(mism[p]);
        end
        err_sum = {1'b0, err_q} + 17'(n_err);
        if (clear_run) begin
            err_d = '0;
        end else if (err_sum[16]) begin
            err_d = 16'hFFFF;
        end else begin
            err_d = err_sum[15:0];
        end
    end

    always_comb begin
        act_sel = '0;
        for (int p = 0; p < NUM_PART; p++) begin
            if (cnt_sel_i == 3'(p)) begin
                act_sel = act_q[p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cyc_q      <= '0;
            epoch_q    <= '0;
            drain_q    <= '0;
            num_ep_q   <= '0;
            duty_q     <= '0;
            park_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            part_vec_q <= '0;
            err_q      <= '0;
            act_cnt_q  <= '0;
            vld_q      <= '0;
            for (int p = 0; p < NUM_PART; p++) begin
                act_q[p] <= '0;
            end
            for (int i = 0; i <= CHECK_LAT; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            cyc_q      <= cyc_d;
            epoch_q    <= epoch_d;
            drain_q    <= drain_d;
            num_ep_q   <= num_ep_d;
            duty_q     <= duty_d;
            park_q     <= park_d;
            lfsr_q     <= lfsr_d;
            part_vec_q <= part_vec_d;
            err_q      <= err_d;
            act_cnt_q  <= act_sel;
            act_q      <= act_d;
            // Stage 0 lines up with the vector as it appears on part_vec_o.
            exp_q[0]   <= golden_all(part_vec_d);
            vld_q[0]   <= (state_q == S_RUN);
            for (int i = 1; i <= CHECK_LAT; i++) begin
                exp_q[i] <= exp_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign part_vec_o  = part_vec_q;
    assign act_cnt_o   = act_cnt_q;
    assign busy_o      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_DONE);
    assign epoch_idx_o = epoch_q;
    assign err_count_o = err_q;
    assign err_flag_o  = (err_q != 16'd0);
    assign state_o     = state_q;

endmodule

// File: tb/tb_c17_stress_scheduler.sv
// Bench for c17_stress_scheduler: partition models with injectable faults, a done-event
// scoreboard for end-of-run status, and directed checks of counters and vectors.
module tb_c17_stress_scheduler;

    localparam int NP   = 4;
    localparam int EL   = 8;
    localparam int CL   = 1;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [15:0]     num_epochs = '0;
    logic [NP*8-1:0] duty_cfg = '0;
    logic [4:0]      park_vec = '0;
    logic [NP*5-1:0] part_vec;
    logic [NP*2-1:0] part_resp = '0;
    logic [2:0]      cnt_sel = '0;
    logic [31:0]     act_cnt;
    logic            busy, done, err_flag;
    logic [15:0]     epoch_idx, err_count;
    logic [2:0]      state;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    int fault_mode = 0;
    logic [32:0] exp_q[$];

    c17_stress_scheduler #(.NUM_PART(NP), .EPOCH_LEN(EL), .CHECK_LAT(CL)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
        .num_epochs_i(num_epochs), .duty_cfg_i(duty_cfg), .park_vec_i(park_vec),
        .part_vec_o(part_vec), .part_resp_i(part_resp), .cnt_sel_i(cnt_sel),
        .act_cnt_o(act_cnt), .busy_o(busy), .done_o(done), .epoch_idx_o(epoch_idx),
        .err_count_o(err_count), .err_flag_o(err_flag), .state_o(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Partition netlist stand-in: {N23,N22} from {N7,N6,N3,N2,N1}, one cycle of latency.
    function automatic logic [1:0] ref_c17(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        {n7, n6, n3, n2, n1} = v;
        n10 = !(n1 && n3);
        n11 = !(n3 && n6);
        n16 = !(n2 && n11);
        n19 = !(n11 && n7);
        return {!(n16 && n19), !(n10 && n16)};
    endfunction

    always @(posedge clk) begin
        logic [NP*2-1:0] r;
        for (int p = 0; p < NP; p++) r[2*p +: 2] = ref_c17(part_vec[5*p +: 5]);
        if (fault_mode == 1) r[2] = 1'b0;
        if (fault_mode == 2) r = ~r;
        part_resp <= r;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        chk_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Scoreboard monitor: each done pulse retires one expected {err_count, err_flag, epoch_idx}.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [32:0] e;
            done_cnt++;
            check("done_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("err_count", 64'(err_count), 64'(e[32:17]));
                check("err_flag", 64'(err_flag), 64'(e[16]));
                check("epoch_idx", 64'(epoch_idx), 64'(e[15:0]));
            end
        end
    end

    task automatic start_run(input logic [15:0] ne, input logic [NP*8-1:0] dc, input logic [4:0] pv);
        @(negedge clk);
        start = 1'b1; num_epochs = ne; duty_cfg = dc; park_vec = pv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 64'(state), 64'(s));
    endtask

    task automatic wait_done(input int budget, output int drain_cycles);
        int n = 0;
        drain_cycles = 0;
        while (done !== 1'b1 && n < budget) begin
            if (state == ST_DRAIN) drain_cycles++;
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'({done, busy, state}), 64'({1'b0, 1'b0, ST_IDLE}));
    endtask

    task automatic read_act(input logic [2:0] sel, input logic [31:0] expv);
        @(negedge clk);
        cnt_sel = sel;
        @(negedge clk);
        check($sformatf("act_cnt[%0d]", sel), 64'(act_cnt), 64'(expv));
    endtask

    initial begin
        int drn, busy_n, done0, pv_bad;
        logic [NP*8-1:0] duty_mix;
        duty_mix = {8'd255, 8'd8, 8'd3, 8'd0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", 64'(state), 64'(ST_IDLE));
        check("rst_outs", 64'({busy, done, err_flag, err_count, epoch_idx, part_vec}), 64'd0);
        check("rst_act_cnt", 64'(act_cnt), 64'd0);

        // num_epochs = 0: LOAD for one cycle, then DONE, vectors never driven.
        exp_q.push_back({16'd0, 1'b0, 16'd0});
        start_run(16'd0, duty_mix, 5'b10101);
        busy_n = 0; pv_bad = 0; done0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            busy_n += int'(busy);
            if (part_vec !== '0) pv_bad = 1;
            @(negedge clk);
        end
        check("zero_ep_busy_cycles", 64'(busy_n), 64'd1);
        check("zero_ep_part_vec", 64'(pv_bad), 64'd0);
        check("zero_ep_done_cnt", 64'(done_cnt - done0), 64'd1);

        // Reset mid-run aborts silently.
        start_run(16'd100, {NP{8'd255}}, 5'b00000);
        repeat (10) @(negedge clk);
        done0 = done_cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state", 64'(state), 64'(ST_IDLE));
        check("midrst_outs", 64'({busy, err_count, epoch_idx, part_vec}), 64'd0);
        repeat (8) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - done0), 64'd0);
        check("midrst_idle", 64'({busy, state}), 64'({1'b0, ST_IDLE}));

        // Two epochs, mixed duty; first vectors come from the seeded LFSR.
        exp_q.push_back({16'd0, 1'b0, 16'd1});
        start_run(16'd2, duty_mix, 5'b10101);
        wait_state(ST_RUN, 10);
        @(negedge clk);
        check("lfsr_v0_p3", 64'(part_vec[19:15]), 64'(5'b00010));
        check("park_v0_p0", 64'(part_vec[4:0]), 64'(5'b10101));
        @(negedge clk);
        check("lfsr_v1_p3", 64'(part_vec[19:15]), 64'(5'b00100));
        wait_done(100, drn);
        check("drain_len", 64'(drn), 64'(CL + 1));
        read_act(3'd0, 32'd0);
        read_act(3'd1, 32'd6);
        read_act(3'd2, 32'd16);
        read_act(3'd3, 32'd16);
        read_act(3'd5, 32'd0);

        // Stop sampled on the third RUN cycle.
        exp_q.push_back({16'd0, 1'b0, 16'd0});
        start_run(16'd5, duty_mix, 5'b01010);
        wait_state(ST_RUN, 10);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(50, drn);
        check("stop_drain_len", 64'(drn), 64'(CL + 1));
        read_act(3'd0, 32'd0);
        read_act(3'd1, 32'd3);
        read_act(3'd2, 32'd3);
        read_act(3'd3, 32'd3);

        // Partition 1 N22 stuck-at-0 while parked on 5'b11111 (golden N22 = 1).
        fault_mode = 1;
        exp_q.push_back({16'd8, 1'b1, 16'd0});
        start_run(16'd1, {NP{8'd0}}, 5'b11111);
        wait_done(50, drn);
        fault_mode = 0;

        // Every partition wrong every cycle: 4 errors/cycle over 17600 cycles saturates.
        fault_mode = 2;
        exp_q.push_back({16'hFFFF, 1'b1, 16'd2199});
        start_run(16'd2200, duty_mix, 5'b00110);
        wait_done(20000, drn);
        fault_mode = 0;
        @(negedge clk);
        check("sat_hold", 64'(err_count), 64'hFFFF);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
